fpmult_pipe_param: RTL and testbench



---
 rtl/fpmult_pipe_param.sv | 202 ++++++++++++++++++++
 tb/tb_fpmult_pipe_param.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpmult_pipe_param.sv
// fpmult_pipe_param: three-stage pipelined floating-point multiplier.
//   S1 unpacks, classifies and forms the exact significand product.
//   S2 normalises and rounds (truncate or round-to-nearest-even).
//   S3 resolves special operands, overflow and underflow, and holds the
//      packed result and exception flags.
// Handshake: a word moves across a boundary only on a cycle where valid and
// ready are both high at the rising edge. Each stage loads when it is empty
// or when its successor takes its content that cycle, so bubbles collapse.
// in_ready is combinational from out_ready through the valid chain. Once
// out_valid is high, out_m and out_flags stay constant until out_ready
// takes them.
module fpmult_pipe_param #(
  parameter int NE = 8,
  parameter int NM = 23
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NE+NM:0]   in_x,
  input  logic [NE+NM:0]   in_y,
  input  logic             rnd_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NE+NM:0]   out_m,
  output logic [3:0]       out_flags
);

  localparam int N  = 1 + NE + NM;
  localparam int EW = NE + 2;
  localparam int PW = 2 * NM + 2;

  localparam logic signed [EW-1:0] BIAS  = EW'((1 << (NE - 1)) - 1);
  localparam logic signed [EW-1:0] EOVF  = EW'((1 << NE) - 1);
  localparam logic signed [EW-1:0] EZERO = '0;
  localparam logic signed [EW-1:0] EONE  = EW'(1);
  localparam logic [N-1:0] QNAN = {1'b0, {NE{1'b1}}, 1'b1, {(NM-1){1'b0}}};

  // Stage valid bits and load enables
  logic v1, v2;
  logic load1, load2, load3;

  assign load3    = ~out_valid | out_ready;
  assign load2    = ~v2 | load3;
  assign load1    = ~v1 | load2;
  assign in_ready = load1;

  // Operand fields and classification
  logic          xs, ys;
  logic [NE-1:0] xe, ye;
  logic [NM-1:0] xm, ym;
  logic          x_zero, y_zero, x_inf, y_inf, x_nan, y_nan;

  assign {xs, xe, xm} = in_x;
  assign {ys, ye, ym} = in_y;
  assign x_zero = (xe == '0);
  assign y_zero = (ye == '0);
  assign x_inf  = (&xe) & ~(|xm);
  assign y_inf  = (&ye) & ~(|ym);
  assign x_nan  = (&xe) & (|xm);
  assign y_nan  = (&ye) & (|ym);

  // Stage 1 registers
  logic                 s1, rnd1, nan1, zinf1, inf1, zero1;
  logic signed [EW-1:0] e1;
  logic [PW-1:0]        p1;

  // Stage 1: capture sign, biased exponent sum, exact product and class
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      v1    <= 1'b0;
      s1    <= 1'b0;
      rnd1  <= 1'b0;
      nan1  <= 1'b0;
      zinf1 <= 1'b0;
      inf1  <= 1'b0;
      zero1 <= 1'b0;
      e1    <= '0;
      p1    <= '0;
    end else if (load1) begin
      v1 <= in_valid;
      if (in_valid) begin
        s1    <= xs ^ ys;
        rnd1  <= rnd_mode;
        nan1  <= x_nan | y_nan;
        zinf1 <= (x_zero & y_inf) | (x_inf & y_zero);
        inf1  <= x_inf | y_inf;
        zero1 <= x_zero | y_zero;
        e1    <= {2'b00, xe} + {2'b00, ye} - BIAS;
        p1    <= PW'({1'b1, xm}) * PW'({1'b1, ym});
      end
    end
  end

  // Normalise and round the stage-1 product
  logic [NM-1:0]        frac;
  logic                 guard, sticky, inc;
  logic [NM:0]          frac_sum;
  logic signed [EW-1:0] e_n;

  // Pick the significand window, derive guard/sticky, apply rounding carry
  always_comb begin
    frac   = '0;
    guard  = 1'b0;
    sticky = 1'b0;
    e_n    = e1;
    if (p1[PW-1]) begin
      frac   = p1[2*NM:NM+1];
      guard  = p1[NM];
      sticky = |p1[NM-1:0];
      e_n    = e1 + EONE;
    end else begin
      frac   = p1[2*NM-1:NM];
      guard  = p1[NM-1];
      sticky = |p1[NM-2:0];
    end
    inc      = rnd1 & guard & (sticky | frac[0]);
    frac_sum = {1'b0, frac} + {{NM{1'b0}}, inc};
    // Rounding up to 2.0 leaves the wrapped fraction at zero; bump exponent
    if (frac_sum[NM]) e_n = e_n + EONE;
  end

  // Stage 2 registers
  logic                 s2, rnd2, nan2, zinf2, inf2, zero2, inx2;
  logic signed [EW-1:0] e2;
  logic [NM-1:0]        man2;

  // Stage 2: hold the rounded significand, exponent and carried class bits
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      v2    <= 1'b0;
      s2    <= 1'b0;
      rnd2  <= 1'b0;
      nan2  <= 1'b0;
      zinf2 <= 1'b0;
      inf2  <= 1'b0;
      zero2 <= 1'b0;
      inx2  <= 1'b0;
      e2    <= '0;
      man2  <= '0;
    end else if (load2) begin
      v2 <= v1;
      if (v1) begin
        s2    <= s1;
        rnd2  <= rnd1;
        nan2  <= nan1;
        zinf2 <= zinf1;
        inf2  <= inf1;
        zero2 <= zero1;
        inx2  <= guard | sticky;
        e2    <= e_n;
        man2  <= frac_sum[NM-1:0];
      end
    end
  end

  // Pack result, in decreasing priority of exceptional cases
  logic [N-1:0] res;
  logic [3:0]   flg;

  // Resolve specials, overflow and underflow before normal packing
  always_comb begin
    res = {s2, e2[NE-1:0], man2};
    flg = {3'b000, inx2};
    if (nan2) begin
      res = QNAN;
      flg = 4'b0000;
    end else if (zinf2) begin
      res = QNAN;
      flg = 4'b1000;
    end else if (inf2) begin
      res = {s2, {NE{1'b1}}, {NM{1'b0}}};
      flg = 4'b0000;
    end else if (zero2) begin
      res = {s2, {(N-1){1'b0}}};
      flg = 4'b0000;
    end else if (e2 >= EOVF) begin
      res = rnd2 ? {s2, {NE{1'b1}}, {NM{1'b0}}}
                 : {s2, {(NE-1){1'b1}}, 1'b0, {NM{1'b1}}};
      flg = 4'b0101;
    end else if (e2 <= EZERO) begin
      res = {s2, {(N-1){1'b0}}};
      flg = 4'b0011;
    end
  end

  // Stage 3: output register, held while the consumer stalls
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      out_valid <= 1'b0;
      out_m     <= '0;
      out_flags <= '0;
    end else if (load3) begin
      out_valid <= v2;
      if (v2) begin
        out_m     <= res;
        out_flags <= flg;
      end
    end
  end

endmodule

// File: tb/tb_fpmult_pipe_param.sv
// tb_fpmult_pipe_param: directed and randomized checks of the pipelined
// multiplier against a value-level reference model (single precision), plus
// a double-precision instance for the wide-format product.
module tb_fpmult_pipe_param;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  // ---------------- single-precision DUT ----------------
  logic        in_valid = 1'b0, in_ready, rnd_mode = 1'b0;
  logic [31:0] in_x = '0, in_y = '0, out_m;
  logic        out_valid, out_ready = 1'b0;
  logic [3:0]  out_flags;

  fpmult_pipe_param #(.NE(8), .NM(23)) dut (
    .clk(clk), .nrst(nrst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .rnd_mode(rnd_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_m(out_m), .out_flags(out_flags)
  );

  // ---------------- double-precision DUT ----------------
  logic        d_in_valid = 1'b0, d_in_ready, d_out_valid;
  logic        d_rnd = 1'b1, d_out_ready = 1'b1;
  logic [63:0] d_x = '0, d_y = '0, d_out_m;
  logic [3:0]  d_out_flags;

  fpmult_pipe_param #(.NE(11), .NM(52)) dut_dp (
    .clk(clk), .nrst(nrst),
    .in_valid(d_in_valid), .in_ready(d_in_ready),
    .in_x(d_x), .in_y(d_y), .rnd_mode(d_rnd),
    .out_valid(d_out_valid), .out_ready(d_out_ready),
    .out_m(d_out_m), .out_flags(d_out_flags)
  );

  // ---------------- scoreboard ----------------
  logic [35:0] exp_q[$];
  int n_pass = 0;
  int n_total = 0;
  int n_pop = 0;
  logic        held_ok = 1'b0;
  logic [35:0] held = '0;

  task automatic chk(input string tag, input logic [67:0] obs, input logic [67:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  // Reference model: works on real values of significands as integers.
  // Result is {flags[3:0], word[31:0]}.
  function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic rnd);
    logic   s, inex, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    int     ea, eb, e, sh;
    longint ma, mb, p, q, r, half;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    ma = longint'(a[22:0]);
    mb = longint'(b[22:0]);
    a_nan  = (ea == 255) && (ma != 0);
    b_nan  = (eb == 255) && (mb != 0);
    a_inf  = (ea == 255) && (ma == 0);
    b_inf  = (eb == 255) && (mb == 0);
    a_zero = (ea == 0);
    b_zero = (eb == 0);
    if (a_nan || b_nan) return {4'b0000, 32'h7FC00000};
    if ((a_zero && b_inf) || (a_inf && b_zero)) return {4'b1000, 32'h7FC00000};
    if (a_inf || b_inf) return {4'b0000, s, 31'h7F800000};
    if (a_zero || b_zero) return {4'b0000, s, 31'h00000000};
    p  = ((longint'(1) << 23) + ma) * ((longint'(1) << 23) + mb);
    e  = ea + eb - 127;
    sh = 23;
    if (p >= (longint'(1) << 47)) begin
      sh = 24;
      e  = e + 1;
    end
    q    = p >> sh;
    r    = p - (q << sh);
    half = longint'(1) << (sh - 1);
    inex = (r != 0);
    if (rnd && ((r > half) || ((r == half) && (q % 2 == 1)))) q = q + 1;
    if (q == (longint'(1) << 24)) begin
      q = longint'(1) << 23;
      e = e + 1;
    end
    if (e >= 255) return {4'b0101, s, rnd ? 31'h7F800000 : 31'h7F7FFFFF};
    if (e <= 0) return {4'b0011, s, 31'h00000000};
    return {3'b000, inex, s, e[7:0], q[22:0]};
  endfunction

  function automatic logic [31:0] gen_op();
    int          k;
    logic [7:0]  e;
    logic [22:0] m;
    k = $urandom_range(0, 15);
    m = 23'($urandom);
    case (k)
      0: e = 8'd0;
      1: begin e = 8'd255; m = '0; end
      2: begin e = 8'd255; m[0] = 1'b1; end
      3: e = 8'($urandom_range(1, 254));
      4: begin e = 8'($urandom_range(100, 150)); m = 23'h7FFFFF; end
      default: e = 8'($urandom_range(64, 190));
    endcase
    return {1'($urandom), e, m};
  endfunction

  // ---------------- driver: one clock cycle ----------------
  task automatic cycle(input logic iv, input logic [31:0] x, input logic [31:0] y,
                       input logic rm, input logic ordy, input logic use_exp,
                       input logic [35:0] expv, output logic acc);
    logic [35:0] e;
    @(negedge clk);
    in_valid  = iv;
    in_x      = x;
    in_y      = y;
    rnd_mode  = rm;
    out_ready = ordy;
    #1;
    if (held_ok) chk("stall_hold", {out_valid, out_flags, out_m}, {1'b1, held});
    held_ok = out_valid && !out_ready;
    held    = {out_flags, out_m};
    if (out_valid && out_ready) begin
      n_pop++;
      if (exp_q.size() == 0) chk("unexpected_pop", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("result", {out_flags, out_m}, e);
      end
    end
    if (!in_ready) chk("full_count", exp_q.size(), 3);
    acc = iv && in_ready;
    if (acc) exp_q.push_back(use_exp ? expv : model(x, y, rm));
    @(posedge clk);
  endtask

  task automatic drain();
    logic acc;
    for (int i = 0; i < 30 && exp_q.size() > 0; i++)
      cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, '0, acc);
    chk("drain_empty", exp_q.size(), 0);
  endtask

  // ---------------- directed table ----------------
  logic [31:0] dx[11], dy[11];
  logic        dr[11];
  logic [35:0] de[11];

  // ---------------- stimulus ----------------
  initial begin
    logic acc, saw_low;
    int idx, pops0, budget, cyc;
    logic [31:0] bx[8], by[8];

    dx[0]  = 32'h3FFFFFFF; dy[0]  = 32'h3FFFFFFF; dr[0]  = 1; de[0]  = {4'h1, 32'h407FFFFE};
    dx[1]  = 32'h3FFFFFFF; dy[1]  = 32'h3FFFFFFF; dr[1]  = 0; de[1]  = {4'h1, 32'h407FFFFE};
    dx[2]  = 32'h3F800001; dy[2]  = 32'h3F800001; dr[2]  = 1; de[2]  = {4'h1, 32'h3F800002};
    dx[3]  = 32'h7F000000; dy[3]  = 32'h7F000000; dr[3]  = 1; de[3]  = {4'h5, 32'h7F800000};
    dx[4]  = 32'h7F000000; dy[4]  = 32'h7F000000; dr[4]  = 0; de[4]  = {4'h5, 32'h7F7FFFFF};
    dx[5]  = 32'h00800000; dy[5]  = 32'h00800000; dr[5]  = 1; de[5]  = {4'h3, 32'h00000000};
    dx[6]  = 32'h80000000; dy[6]  = 32'h7F800000; dr[6]  = 1; de[6]  = {4'h8, 32'h7FC00000};
    dx[7]  = 32'hFF800000; dy[7]  = 32'h40000000; dr[7]  = 1; de[7]  = {4'h0, 32'hFF800000};
    dx[8]  = 32'h3FC00001; dy[8]  = 32'h3FC00001; dr[8]  = 1; de[8]  = {4'h1, 32'h40100002};
    dx[9]  = 32'h3FC00001; dy[9]  = 32'h3FC00001; dr[9]  = 0; de[9]  = {4'h1, 32'h40100001};
    dx[10] = 32'h3F800001; dy[10] = 32'h3F800001; dr[10] = 0; de[10] = {4'h1, 32'h3F800002};

    // Reset state
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_m", out_m, 0);
    chk("rst_out_flags", out_flags, 0);
    chk("rst_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    nrst = 1'b1;
    #1 chk("post_rst_in_ready", in_ready, 1);

    // Basic product and latency
    cycle(1'b1, 32'h3FC00000, 32'h40000000, 1'b1, 1'b1, 1'b1, {4'h0, 32'h40400000}, acc);
    chk("basic_accept", acc, 1);
    #1 chk("lat_edge_k", out_valid, 0);
    cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, '0, acc);
    #1 chk("lat_edge_k1", out_valid, 0);
    cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, '0, acc);
    #1 chk("lat_edge_k2", out_valid, 1);
    drain();

    // Directed rounding / overflow / underflow / specials, back to back
    idx = 0;
    for (int i = 0; i < 40 && idx < 11; i++) begin
      cycle(1'b1, dx[idx], dy[idx], dr[idx], 1'b1, 1'b1, de[idx], acc);
      if (acc) idx++;
    end
    chk("directed_all_sent", idx, 11);
    drain();

    // Backpressure: 8 distinct operands, consumer stalled for 5 cycles
    for (int i = 0; i < 8; i++) begin
      bx[i] = {2'b00, 6'($urandom_range(20, 40)) + 6'd0, 24'($urandom)} | 32'h3E000000;
      by[i] = 32'h3F800000 + 32'(i);
    end
    pops0 = n_pop;
    saw_low = 1'b0;
    idx = 0;
    cyc = 0;
    for (budget = 0; budget < 60 && (idx < 8 || exp_q.size() > 0); budget++) begin
      cycle(idx < 8, bx[idx % 8], by[idx % 8], 1'b1, !(cyc >= 3 && cyc < 8), 1'b0, '0, acc);
      if (!in_ready) saw_low = 1'b1;
      if (acc) idx++;
      cyc++;
    end
    chk("bp_in_ready_fell", saw_low, 1);
    chk("bp_results", n_pop - pops0, 8);
    drain();

    // Randomized traffic with random stalls and rounding modes
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 3) != 0, gen_op(), gen_op(), 1'($urandom),
            $urandom_range(0, 2) != 0, 1'b0, '0, acc);
    drain();

    // Reset with the pipe full
    for (int i = 0; i < 10 && in_ready; i++)
      cycle(1'b1, gen_op(), gen_op(), 1'b1, 1'b0, 1'b0, '0, acc);
    chk("mid_full", exp_q.size(), 3);
    @(negedge clk);
    nrst = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    exp_q.delete();
    held_ok = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    nrst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, '0, acc);
      chk("no_stale_out", out_valid, 0);
    end

    // Short random burst after reset release
    for (int i = 0; i < 60; i++)
      cycle(1'b1, gen_op(), gen_op(), 1'($urandom), $urandom_range(0, 1) != 0, 1'b0, '0, acc);
    drain();

    // Double precision basic product and overflow
    @(negedge clk);
    d_x = 64'h3FF8000000000000;
    d_y = 64'h4000000000000000;
    d_in_valid = 1'b1;
    #1 chk("dp_in_ready", d_in_ready, 1);
    @(negedge clk);
    d_x = 64'h7FE0000000000000;
    d_y = 64'h7FE0000000000000;
    @(negedge clk);
    d_in_valid = 1'b0;
    for (int i = 0; i < 10 && !d_out_valid; i++) @(negedge clk);
    #1;
    chk("dp_valid", d_out_valid, 1);
    chk("dp_basic", {d_out_flags, d_out_m}, {4'h0, 64'h4008000000000000});
    @(negedge clk);
    #1;
    chk("dp_ovf_valid", d_out_valid, 1);
    chk("dp_ovf", {d_out_flags, d_out_m}, {4'h5, 64'h7FF0000000000000});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
